// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
// Contents: bus widths, stall-vector encodings, FSM state type and the
// saturation limit of the consecutive-stall run counter.
package pipe_ctrl_pkg;

  localparam int RegAddrBus  = 5;
  localparam int InstAddrBus = 32;
  localparam int StallBus    = 6;
  localparam int CountBus    = 32;
  localparam int RunBus      = 8;

  // One bit per stage: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
  localparam logic [StallBus-1:0] STALL_NONE = 6'b000000;
  localparam logic [StallBus-1:0] STALL_ID   = 6'b000111;
  localparam logic [StallBus-1:0] STALL_EX   = 6'b001111;

  localparam logic [RunBus-1:0] RUN_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Interface bundling the pipeline controller's request and response signals.
// master: the pipeline stages (drive requests, observe stall/flush/stats).
// slave : the controller (observe requests, drive stall/flush/stats).
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                   stallreq_id;
  logic                   stallreq_ex;
  logic                   ex_is_load;
  logic [RegAddrBus-1:0]  ex_wd;
  logic                   id_reg1_read;
  logic                   id_reg2_read;
  logic [RegAddrBus-1:0]  id_reg1_addr;
  logic [RegAddrBus-1:0]  id_reg2_addr;
  logic                   flush_req;
  logic [InstAddrBus-1:0] flush_pc;
  logic [StallBus-1:0]    stall;
  logic                   flush;
  logic [InstAddrBus-1:0] new_pc;
  logic [CountBus-1:0]    stall_cycles;
  logic                   stall_timeout;

  modport master (
    output stallreq_id, stallreq_ex, ex_is_load, ex_wd,
           id_reg1_read, id_reg2_read, id_reg1_addr, id_reg2_addr,
           flush_req, flush_pc,
    input  stall, flush, new_pc, stall_cycles, stall_timeout
  );

  modport slave (
    input  stallreq_id, stallreq_ex, ex_is_load, ex_wd,
           id_reg1_read, id_reg2_read, id_reg1_addr, id_reg2_addr,
           flush_req, flush_pc,
    output stall, flush, new_pc, stall_cycles, stall_timeout
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use hazard detector.
// Ports: ex_is_load/ex_wd describe the instruction in EX; id_reg*_read and
// id_reg*_addr describe the operands decoded in ID; load_use flags a hazard.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  ex_is_load,
  input  logic [RegAddrBus-1:0] ex_wd,
  input  logic                  id_reg1_read,
  input  logic [RegAddrBus-1:0] id_reg1_addr,
  input  logic                  id_reg2_read,
  input  logic [RegAddrBus-1:0] id_reg2_addr,
  output logic                  load_use
);

  // Register 0 is hardwired to zero, so a load into it never creates a hazard.
  assign load_use = ex_is_load && (ex_wd != '0) &&
                    ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
                     (id_reg2_read && (id_reg2_addr == ex_wd)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
// Ports: clk (rising edge), rst (synchronous, active-high), bus (slave side
// of pipe_ctrl_if). Produces a per-stage stall vector in the same cycle as its
// causes, a one-cycle-per-request flush with redirect target, a free-running
// stalled-cycle counter and a sticky watchdog for 255 consecutive stalls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  state_e                 state_q, state_d;
  logic [InstAddrBus-1:0] new_pc_q;
  logic [CountBus-1:0]    stall_cycles_q;
  logic [RunBus-1:0]      run_q, run_d;
  logic                   timeout_q;
  logic                   load_use;
  logic [StallBus-1:0]    stall_s;
  logic                   flush_s;

  hazard_detect u_hazard (
    .ex_is_load   (bus.ex_is_load),
    .ex_wd        (bus.ex_wd),
    .id_reg1_read (bus.id_reg1_read),
    .id_reg1_addr (bus.id_reg1_addr),
    .id_reg2_read (bus.id_reg2_read),
    .id_reg2_addr (bus.id_reg2_addr),
    .load_use     (load_use)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next-state logic: a redirect wins from any state, including FLUSH itself.
  always_comb begin
    state_d = ST_RUN;
    if (bus.flush_req)             state_d = ST_FLUSH;
    else if (stall_s != STALL_NONE) state_d = ST_STALL;
  end

  // Output logic: flush suppresses all stalls, EX stall outranks ID stall.
  always_comb begin
    stall_s = STALL_NONE;
    flush_s = (state_q == ST_FLUSH);
    if (!rst && !flush_s) begin
      if (bus.stallreq_ex)                   stall_s = STALL_EX;
      else if (bus.stallreq_id || load_use)  stall_s = STALL_ID;
    end
  end

  // Run counter clears whenever the pipe moves (stall is already 0 in FLUSH)
  // and saturates at RUN_MAX so the watchdog condition stays stable.
  always_comb begin
    run_d = '0;
    if (stall_s != STALL_NONE) begin
      run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      new_pc_q       <= '0;
      stall_cycles_q <= '0;
      run_q          <= '0;
      timeout_q      <= 1'b0;
    end else begin
      if (bus.flush_req) new_pc_q <= bus.flush_pc;
      if (stall_s != STALL_NONE) stall_cycles_q <= stall_cycles_q + 32'd1;
      run_q     <= run_d;
      timeout_q <= timeout_q | (run_d == RUN_MAX);
    end
  end

  assign bus.stall         = stall_s;
  assign bus.flush         = flush_s;
  assign bus.new_pc        = new_pc_q;
  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.stall_timeout = timeout_q;

endmodule
